uart_host_rx: RTL and testbench
===============================

UART_HOST_RX -- requirements
Module: uart_host_rx

Interface
REQ-001 The block SHALL expose parameter CLKS_PER_BIT, default 868, clocks per serial bit (100 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL expose parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rx  input  1  serial line driven by the CPU's Tx; idle high; 8N1, LSB first.
REQ-006 rd_en  input  1  pop request for the FIFO head.
REQ-007 clr_err  input  1  one-cycle pulse clearing the sticky error flags.
REQ-008 rd_data  output  8  FIFO head byte, first-word-fall-through; valid while empty=0.
REQ-009 empty  output  1  FIFO holds no bytes.
REQ-010 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 overflow  output  1  sticky; a good byte was dropped because the FIFO was full.
REQ-012 frame_err  output  1  sticky; a stop bit sampled low.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (reset value 1); all decoding SHALL use the synchronized value rxs.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP and an armed flag; the armed flag SHALL be set whenever rxs=1 in IDLE.
REQ-015 IDLE->START SHALL occur when armed=1 and rxs=0; the bit counter SHALL load CLKS_PER_BIT/2-1 (integer division).
REQ-016 START: when the counter reaches 0, rxs=0 SHALL go to DATA with the counter set to CLKS_PER_BIT-1 and the bit index set to 0; rxs=1 is a glitch and SHALL go to IDLE with no flag change.
REQ-017 DATA: at each counter expiry, rxs SHALL be shifted in at the bit index (LSB first) and the counter reloaded; after bit index 7 the FSM SHALL go to STOP.
REQ-018 STOP: at counter expiry, rxs=1 SHALL push the byte and go to IDLE; rxs=0 SHALL set frame_err, discard the byte, go to IDLE and clear armed.
REQ-019 All sample points SHALL lie at bit centres: start + k*CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after the falling edge is seen on rxs.
REQ-020 A pushed byte SHALL appear on rd_data with empty=0 on the cycle after the stop-bit sample.
REQ-021 A push while full with no pop in the same cycle SHALL drop the byte and set overflow; FIFO contents SHALL be unchanged.
REQ-022 A push and a pop in the same cycle SHALL both take effect with count unchanged, even when full; overflow SHALL NOT be set.
REQ-023 rd_en while empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 When clr_err and a new error coincide in a cycle, the error SHALL win and the flag SHALL stay 1.
REQ-025 The FIFO count SHALL be log2(FIFO_DEPTH)+1 bits wide; full SHALL be count==FIFO_DEPTH and empty SHALL be count==0.

Reset
REQ-026 On rst=1 at a clock edge: FSM=IDLE, armed=0, synchronizer=1, counters=0, FIFO pointers and count=0, empty=1, full=0, overflow=0, frame_err=0, rd_data=0.
REQ-027 rst asserted mid-frame SHALL abort the frame with no push; after release, reception SHALL wait for rxs=1 before a new start is accepted.
REQ-028 FIFO storage contents need no reset; rd_data SHALL read 0 while empty.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-029 Send 0xA5 8N1 -> 1 cycle after the stop sample: rd_data=0xA5, empty=0; rd_en pulse -> empty=1.
REQ-030 Pulse rx low for 3 cycles from idle -> FSM returns to IDLE, empty=1, frame_err=0.
REQ-031 Send 0x3C with stop bit 0, then the line high for 10 bit times, then 0x11 -> frame_err=1, FIFO holds only 0x11; clr_err -> frame_err=0.
REQ-032 Send 0x01..0x05 with no reads -> full=1 after 0x04, overflow=1 after 0x05; pops return 0x01,0x02,0x03,0x04.
REQ-033 With FIFO full, assert rd_en in the stop-sample cycle of a 5th byte 0x77 -> overflow=0, count=4, last pop returns 0x77.
REQ-034 Assert rst during bit 4 of 0xFF, release, send 0x5A -> only 0x5A is received, flags are 0.

Source files
------------

// File: rtl/uart_host_rx.sv
// 8N1 UART receiver for a host link: 2-flop synchronizer, centre-sampling FSM
// and a small first-word-fall-through receive FIFO with sticky error flags.
module uart_host_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0]   HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]   BIT_M1   = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic          rx_meta_q, rxs_q;
  state_e        state_q;
  logic          armed_q;
  logic [15:0]   cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shreg_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, frame_err_q;
  logic          stop_tick, push, bad_stop, pop_ok, push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // The armed flag keeps a line that is still low (after reset or a bad
  // stop bit) from being mistaken for a fresh start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rxs_q) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= START;
            cnt_q   <= HALF_M1;
          end
        end
        START: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (!rxs_q) begin
            state_q <= DATA;
            cnt_q   <= BIT_M1;
            idx_q   <= 3'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            shreg_q[idx_q] <= rxs_q;
            cnt_q          <= BIT_M1;
            if (idx_q == 3'd7) state_q <= STOP;
            else               idx_q   <= idx_q + 3'd1;
          end
        end
        STOP: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            state_q <= IDLE;
            if (!rxs_q) armed_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stop_tick = (state_q == STOP) && (cnt_q == 16'd0);
  assign push      = stop_tick && rxs_q;
  assign bad_stop  = stop_tick && !rxs_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign pop_ok    = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign push_ok   = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
  end

  // A new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow_q  <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (push && full && !pop_ok) overflow_q  <= 1'b1;
      if (bad_stop)                frame_err_q <= 1'b1;
    end
  end

  assign rd_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_host_rx.sv
// Directed bench for uart_host_rx at 8 clocks per bit and a 4-entry FIFO.
module tb_uart_host_rx;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, rx, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       empty, full, overflow, frame_err;
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  uart_host_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .empty(empty), .full(full),
    .overflow(overflow), .frame_err(frame_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Start bit plus eight data bits; returns with the stop-bit period about to begin.
  task automatic send_frame(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  // Stop bit, with optional rd_en/clr_err held across the stop-sample edge.
  task automatic finish_stop(input logic stop, input logic pop, input logic clr);
    rx = stop;
    tick(6);
    rd_en   = pop;
    clr_err = clr;
    tick(1);
    rd_en   = 1'b0;
    clr_err = 1'b0;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d);
    finish_stop(1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    tick(2);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_ferr", 32'(frame_err), 32'd0);
    check_val("rst_data", 32'(rd_data), 32'h00);

    // 0xA5: still empty one edge before the stop sample, visible right after it
    send_frame(8'hA5);
    rx = 1'b1;
    tick(6);
    check_val("a5_pre_empty", 32'(empty), 32'd1);
    tick(1);
    check_val("a5_empty", 32'(empty), 32'd0);
    check_val("a5_data", 32'(rd_data), 32'hA5);
    tick(2);
    pop_one();
    check_val("a5_pop_empty", 32'(empty), 32'd1);
    check_val("a5_pop_data", 32'(rd_data), 32'h00);

    // 3-cycle glitch is rejected at the start-bit centre
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    check_val("glitch_empty", 32'(empty), 32'd1);
    check_val("glitch_ferr", 32'(frame_err), 32'd0);

    // Bad stop bit with clr_err in the same cycle: the error must win
    send_frame(8'h3C);
    finish_stop(1'b0, 1'b0, 1'b1);
    check_val("fe_flag", 32'(frame_err), 32'd1);
    check_val("fe_empty", 32'(empty), 32'd1);
    rx = 1'b1;
    tick(10 * CPB);
    send_byte(8'h11);
    check_val("fe_keep", 32'(frame_err), 32'd1);
    check_val("fe_next_data", 32'(rd_data), 32'h11);
    pop_one();
    check_val("fe_only_one", 32'(empty), 32'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check_val("fe_clr", 32'(frame_err), 32'd0);

    // Fill to full, then overflow on the fifth byte
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i));
      if (i == 3) check_val("fill_not_full", 32'(full), 32'd0);
    end
    check_val("fill_full", 32'(full), 32'd1);
    check_val("fill_no_ovf", 32'(overflow), 32'd0);
    send_byte(8'h05);
    check_val("ovf_flag", 32'(overflow), 32'd1);
    check_val("ovf_full", 32'(full), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check_val("ovf_pop_data", 32'(rd_data), 32'(i));
      pop_one();
    end
    check_val("ovf_drained", 32'(empty), 32'd1);
    pop_one();
    check_val("pop_empty_ignored", 32'(empty), 32'd1);
    check_val("pop_empty_full", 32'(full), 32'd0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check_val("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO, pop coincident with the push of 0x77
    for (int i = 1; i <= 4; i++) send_byte(8'(8'h20 + i));
    check_val("pp_full_before", 32'(full), 32'd1);
    send_frame(8'h77);
    finish_stop(1'b1, 1'b1, 1'b0);
    rx = 1'b1;
    check_val("pp_no_ovf", 32'(overflow), 32'd0);
    check_val("pp_still_full", 32'(full), 32'd1);
    check_val("pp_head0", 32'(rd_data), 32'h22);
    pop_one();
    check_val("pp_head1", 32'(rd_data), 32'h23);
    pop_one();
    check_val("pp_head2", 32'(rd_data), 32'h24);
    pop_one();
    check_val("pp_last", 32'(rd_data), 32'h77);
    pop_one();
    check_val("pp_empty", 32'(empty), 32'd1);

    // Reset in the middle of bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check_val("mid_rst_empty", 32'(empty), 32'd1);
    check_val("mid_rst_data", 32'(rd_data), 32'h00);
    tick(6 * CPB);
    send_byte(8'h5A);
    check_val("mid_rst_rx", 32'(rd_data), 32'h5A);
    check_val("mid_rst_ferr", 32'(frame_err), 32'd0);
    check_val("mid_rst_ovf", 32'(overflow), 32'd0);
    pop_one();
    check_val("mid_rst_single", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
